// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the RV32I pipeline.
//   XLEN            datapath width
//   ALU_*           3-bit ALU control codes produced by the ALU decoder
//   FWD_*           operand forwarding select codes (11 is reserved, acts as FWD_REG)
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] ALU_ADD_SUB = 3'b000;  // add, or subtract when sral=1
  localparam logic [2:0] ALU_SLL     = 3'b001;
  localparam logic [2:0] ALU_AND     = 3'b010;
  localparam logic [2:0] ALU_OR      = 3'b011;
  localparam logic [2:0] ALU_SLTU    = 3'b100;
  localparam logic [2:0] ALU_SLT     = 3'b101;
  localparam logic [2:0] ALU_XOR     = 3'b110;
  localparam logic [2:0] ALU_SHR     = 3'b111;  // logical when sral=1, arithmetic when sral=0

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu.sv
// alu: purely combinational RV32I ALU.
// Ports:
//   a, b     [XLEN] operands (b[4:0] is the shift amount for shifts)
//   control  [3]    operation code (riscv_pkg::ALU_*)
//   sral     [1]    modifier: subtract for ALU_ADD_SUB, logical shift for ALU_SHR
//   result   [XLEN] operation result; SLT/SLTU zero-extended
module alu import riscv_pkg::*; (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      control,
  input  logic            sral,
  output logic [XLEN-1:0] result
);

  logic [4:0]             shamt;
  logic signed [XLEN-1:0] sra_res;

  assign shamt = b[4:0];
  // Kept in its own signed net so the arithmetic shift is never
  // evaluated in an unsigned expression context.
  assign sra_res = $signed(a) >>> shamt;

  always_comb begin
    result = '0;
    case (control)
      ALU_ADD_SUB: result = sral ? (a - b) : (a + b);
      ALU_SLL:     result = a << shamt;
      ALU_AND:     result = a & b;
      ALU_OR:      result = a | b;
      ALU_SLTU:    result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_SLT:     result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_XOR:     result = a ^ b;
      ALU_SHR: begin
        if (sral) result = a >> shamt;
        else      result = sra_res;
      end
      default:     result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage RV32I pipeline.
// Holds the ID/EX register, the operand forwarding muxes, one ALU instance
// and the EX/MEM result register.
// Configuration macro: EX_FORWARD_EN
//   defined   -> forward_a_e / forward_b_e select between the register value,
//                result_w (01) and alu_result_m (10); 11 behaves like 00.
//   undefined -> operands come only from ID/EX; forward_*_e and result_w are
//                accepted but ignored (hazards are resolved by stalling).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   stall_e, flush_e           hold ID/EX (bubble into EX/MEM) / clear ID/EX valid
//   valid_d .. reg_write_d     decode-stage instruction fields
//   forward_a_e, forward_b_e   forwarding selects for the instruction in EX
//   result_w                   writeback result for forwarding
//   alu_result_m, write_data_m, rd_m, reg_write_m, valid_m   EX/MEM register
//   zero_e, pc_target_e        combinational branch flag and target
module ex_stage import riscv_pkg::*; (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_e,
  input  logic            flush_e,
  input  logic            valid_d,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [XLEN-1:0] imm_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic            alu_src_d,
  input  logic [2:0]      alu_control_d,
  input  logic            sral_d,
  input  logic [4:0]      rd_d,
  input  logic            reg_write_d,
  input  logic [1:0]      forward_a_e,
  input  logic [1:0]      forward_b_e,
  input  logic [XLEN-1:0] result_w,
  output logic [XLEN-1:0] alu_result_m,
  output logic [XLEN-1:0] write_data_m,
  output logic [4:0]      rd_m,
  output logic            reg_write_m,
  output logic            valid_m,
  output logic            zero_e,
  output logic [XLEN-1:0] pc_target_e
);

  // ID/EX register fields
  logic            valid_e;
  logic [XLEN-1:0] rd1_e;
  logic [XLEN-1:0] rd2_e;
  logic [XLEN-1:0] imm_e;
  logic [XLEN-1:0] pc_e;
  logic            alu_src_e;
  logic [2:0]      alu_control_e;
  logic            sral_e;
  logic [4:0]      rd_e;
  logic            reg_write_e;

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;   // forwarded rd2, also the store data
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result_e;

  // Flush outranks stall so a squashed instruction can never be held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_e       <= 1'b0;
      rd1_e         <= '0;
      rd2_e         <= '0;
      imm_e         <= '0;
      pc_e          <= '0;
      alu_src_e     <= 1'b0;
      alu_control_e <= '0;
      sral_e        <= 1'b0;
      rd_e          <= '0;
      reg_write_e   <= 1'b0;
    end else if (flush_e) begin
      valid_e       <= 1'b0;
      rd1_e         <= '0;
      rd2_e         <= '0;
      imm_e         <= '0;
      pc_e          <= '0;
      alu_src_e     <= 1'b0;
      alu_control_e <= '0;
      sral_e        <= 1'b0;
      rd_e          <= '0;
      reg_write_e   <= 1'b0;
    end else if (!stall_e) begin
      valid_e       <= valid_d;
      rd1_e         <= rd1_d;
      rd2_e         <= rd2_d;
      imm_e         <= imm_d;
      pc_e          <= pc_d;
      alu_src_e     <= alu_src_d;
      alu_control_e <= alu_control_d;
      sral_e        <= sral_d;
      rd_e          <= rd_d;
      reg_write_e   <= reg_write_d;
    end
  end

`ifdef EX_FORWARD_EN
  always_comb begin
    case (forward_a_e)
      FWD_WB:  src_a = result_w;
      FWD_MEM: src_a = alu_result_m;
      default: src_a = rd1_e;
    endcase
    case (forward_b_e)
      FWD_WB:  fwd_b = result_w;
      FWD_MEM: fwd_b = alu_result_m;
      default: fwd_b = rd2_e;
    endcase
  end
`else
  assign src_a = rd1_e;
  assign fwd_b = rd2_e;
  // Forwarding inputs stay on the port list but have no function here.
  logic unused_fwd;
  assign unused_fwd = ^{forward_a_e, forward_b_e, result_w};
`endif

  assign src_b = alu_src_e ? imm_e : fwd_b;

  alu u_alu (
    .a       (src_a),
    .b       (src_b),
    .control (alu_control_e),
    .sral    (sral_e),
    .result  (alu_result_e)
  );

  assign zero_e      = valid_e && (alu_result_e == '0);
  assign pc_target_e = pc_e + imm_e;

  // A bubble only clears the control bits; data fields keep their last value
  // so alu_result_m remains a stable forwarding source.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_result_m <= '0;
      write_data_m <= '0;
      rd_m         <= '0;
      reg_write_m  <= 1'b0;
      valid_m      <= 1'b0;
    end else if (stall_e || !valid_e) begin
      reg_write_m  <= 1'b0;
      valid_m      <= 1'b0;
    end else begin
      alu_result_m <= alu_result_e;
      write_data_m <= fwd_b;
      rd_m         <= rd_e;
      reg_write_m  <= reg_write_e;
      valid_m      <= 1'b1;
    end
  end

endmodule
